// File: rtl/child_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// child_sprite_ctrl
//
// Frame-synchronous controller for the child sprite. It holds the sprite
// center position, the walk animation pose and the hit/invulnerability state.
// It feeds the child sprite ROM address generator. All outputs are registered.
// Apart from HIT entry, they only change on a frame_tick edge, so the pixel
// path sees stable values for a whole frame.
//
// Ports
//   Clk         in   system clock
//   Reset_n     in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per video frame (synchronous to Clk)
//   move_left   in   held-key level
//   move_right  in   held-key level
//   move_up     in   held-key level
//   move_down   in   held-key level
//   hit_req     in   collision pulse, may arrive on any cycle
//   centerx     out  [9:0] sprite center x
//   centery     out  [9:0] sprite center y
//   run_child   out  [1:0] frame select: 0 still, 1 run pose, 2 hit pose
//   hit         out  high while in HIT
//   show_child  out  sprite visible
// -----------------------------------------------------------------------------
module child_sprite_ctrl #(
   parameter int unsigned STEP         = 2,
   parameter int unsigned ANIM_FRAMES  = 8,
   parameter int unsigned HIT_FRAMES   = 60,
   parameter int unsigned BLINK_FRAMES = 4,
   parameter int unsigned X_MIN        = 29,
   parameter int unsigned X_MAX        = 610,
   parameter int unsigned Y_MIN        = 30,
   parameter int unsigned Y_MAX        = 449,
   parameter int unsigned X_INIT       = 320,
   parameter int unsigned Y_INIT       = 240
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       move_up,
   input  logic       move_down,
   input  logic       hit_req,
   output logic [9:0] centerx,
   output logic [9:0] centery,
   output logic [1:0] run_child,
   output logic       hit,
   output logic       show_child
);

   localparam int unsigned ANIM_W  = (ANIM_FRAMES  > 1) ? $clog2(ANIM_FRAMES)  : 1;
   localparam int unsigned HIT_W   = (HIT_FRAMES   > 1) ? $clog2(HIT_FRAMES)   : 1;
   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_FRAMES - 1);
   localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HIT_FRAMES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   localparam logic signed [10:0] STEP_S  = 11'(STEP);
   localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
   localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
   localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
   localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

   localparam logic [1:0] POSE_STILL = 2'd0;
   localparam logic [1:0] POSE_RUN   = 2'd1;
   localparam logic [1:0] POSE_HIT   = 2'd2;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHit  = 2'd2
   } state_t;

   // Registered state
   state_t             r_state;
   logic [9:0]         r_cx;
   logic [9:0]         r_cy;
   logic [1:0]         r_run_child;
   logic               r_hit;
   logic               r_show;
   logic [ANIM_W-1:0]  r_anim_cnt;
   logic [HIT_W-1:0]   r_hit_cnt;
   logic [BLINK_W-1:0] r_blink_cnt;

   // Next-state values
   state_t             w_state_nxt;
   logic [9:0]         w_cx_nxt;
   logic [9:0]         w_cy_nxt;
   logic [1:0]         w_run_child_nxt;
   logic               w_hit_nxt;
   logic               w_show_nxt;
   logic [ANIM_W-1:0]  w_anim_cnt_nxt;
   logic [HIT_W-1:0]   w_hit_cnt_nxt;
   logic [BLINK_W-1:0] w_blink_cnt_nxt;

   // Net per-axis motion and the clamped candidate positions
   logic signed [10:0] w_dx;
   logic signed [10:0] w_dy;
   logic               w_moving;
   logic [9:0]         w_cx_moved;
   logic [9:0]         w_cy_moved;

   // Add a signed delta in 11 bits and clamp into [lo, hi]. The 11-bit sum
   // keeps a step below zero negative so it clamps to lo instead of wrapping.
   function automatic logic [9:0] clamp_axis(input logic [9:0]         c,
                                             input logic signed [10:0] d,
                                             input logic signed [10:0] lo,
                                             input logic signed [10:0] hi);
      logic signed [10:0] sum;
      logic signed [10:0] res;
      sum = $signed({1'b0, c}) + d;
      if (sum < lo) begin
         res = lo;
      end else if (sum > hi) begin
         res = hi;
      end else begin
         res = sum;
      end
      return 10'(res);
   endfunction

   // Both keys held or neither held cancels to zero on that axis
   always_comb begin
      w_dx = '0;
      w_dy = '0;
      unique case ({move_right, move_left})
         2'b10:   w_dx = STEP_S;
         2'b01:   w_dx = -STEP_S;
         default: w_dx = '0;
      endcase
      unique case ({move_down, move_up})
         2'b10:   w_dy = STEP_S;
         2'b01:   w_dy = -STEP_S;
         default: w_dy = '0;
      endcase
   end

   assign w_moving   = (w_dx != 11'sd0) || (w_dy != 11'sd0);
   assign w_cx_moved = clamp_axis(r_cx, w_dx, X_MIN_S, X_MAX_S);
   assign w_cy_moved = clamp_axis(r_cy, w_dy, Y_MIN_S, Y_MAX_S);

   always_comb begin
      w_state_nxt     = r_state;
      w_cx_nxt        = r_cx;
      w_cy_nxt        = r_cy;
      w_run_child_nxt = r_run_child;
      w_hit_nxt       = r_hit;
      w_show_nxt      = r_show;
      w_anim_cnt_nxt  = r_anim_cnt;
      w_hit_cnt_nxt   = r_hit_cnt;
      w_blink_cnt_nxt = r_blink_cnt;

      unique case (r_state)
         StIdle, StRun: begin
            if (hit_req) begin
               // A collision beats a coincident frame_tick, so no motion is applied
               w_state_nxt     = StHit;
               w_hit_nxt       = 1'b1;
               w_run_child_nxt = POSE_HIT;
               w_hit_cnt_nxt   = '0;
               w_blink_cnt_nxt = '0;
               w_show_nxt      = 1'b1;
            end else if (frame_tick) begin
               if (w_moving) begin
                  w_cx_nxt = w_cx_moved;
                  w_cy_nxt = w_cy_moved;
                  if (r_state == StIdle) begin
                     w_state_nxt     = StRun;
                     w_anim_cnt_nxt  = '0;
                     w_run_child_nxt = POSE_RUN;
                  end else if (r_anim_cnt == ANIM_LAST) begin
                     w_anim_cnt_nxt  = '0;
                     w_run_child_nxt = (r_run_child == POSE_RUN) ? POSE_STILL : POSE_RUN;
                  end else begin
                     w_anim_cnt_nxt = r_anim_cnt + 1'b1;
                  end
               end else begin
                  w_state_nxt     = StIdle;
                  w_run_child_nxt = POSE_STILL;
               end
            end
         end

         StHit: begin
            // Position is frozen; keys and further hit_req are ignored
            if (frame_tick) begin
               if (r_hit_cnt == HIT_LAST) begin
                  w_state_nxt     = StIdle;
                  w_hit_nxt       = 1'b0;
                  w_run_child_nxt = POSE_STILL;
                  w_show_nxt      = 1'b1;
                  w_hit_cnt_nxt   = '0;
                  w_blink_cnt_nxt = '0;
               end else begin
                  w_hit_cnt_nxt = r_hit_cnt + 1'b1;
                  if (r_blink_cnt == BLINK_LAST) begin
                     w_blink_cnt_nxt = '0;
                     w_show_nxt      = ~r_show;
                  end else begin
                     w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                  end
               end
            end
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= StIdle;
         r_cx        <= 10'(X_INIT);
         r_cy        <= 10'(Y_INIT);
         r_run_child <= POSE_STILL;
         r_hit       <= 1'b0;
         r_show      <= 1'b1;
         r_anim_cnt  <= '0;
         r_hit_cnt   <= '0;
         r_blink_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cx        <= w_cx_nxt;
         r_cy        <= w_cy_nxt;
         r_run_child <= w_run_child_nxt;
         r_hit       <= w_hit_nxt;
         r_show      <= w_show_nxt;
         r_anim_cnt  <= w_anim_cnt_nxt;
         r_hit_cnt   <= w_hit_cnt_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
      end
   end

   assign centerx    = r_cx;
   assign centery    = r_cy;
   assign run_child  = r_run_child;
   assign hit        = r_hit;
   assign show_child = r_show;

endmodule

// File: tb/tb_child_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// tb_child_sprite_ctrl
//
// Directed and random stimulus for child_sprite_ctrl. A frame-level reference
// model tracks position, walk pose and hit/blink timing using tick counts.
// ---------------------------------------------------------------------------
module tb_child_sprite_ctrl;

   localparam int STEP   = 2;
   localparam int ANIM   = 8;
   localparam int HITF   = 60;
   localparam int BLINK  = 4;
   localparam int XMIN   = 29;
   localparam int XMAX   = 610;
   localparam int YMIN   = 30;
   localparam int YMAX   = 449;
   localparam int XINIT  = 320;
   localparam int YINIT  = 240;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       move_up = 1'b0;
   logic       move_down = 1'b0;
   logic       hit_req = 1'b0;
   logic [9:0] centerx;
   logic [9:0] centery;
   logic [1:0] run_child;
   logic       hit;
   logic       show_child;

   int total = 0;
   int bad   = 0;

   // Reference model
   int m_x, m_y, m_pose, m_hit, m_show;
   bit m_walking;
   int m_walk_idx;
   int m_hit_ticks;

   child_sprite_ctrl dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_tick (frame_tick),
      .move_left  (move_left),
      .move_right (move_right),
      .move_up    (move_up),
      .move_down  (move_down),
      .hit_req    (hit_req),
      .centerx    (centerx),
      .centery    (centery),
      .run_child  (run_child),
      .hit        (hit),
      .show_child (show_child)
   );

   always #5 Clk = ~Clk;

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      m_x = XINIT; m_y = YINIT; m_pose = 0; m_hit = 0; m_show = 1;
      m_walking = 1'b0; m_walk_idx = 0; m_hit_ticks = 0;
   endtask

   // One clock edge of behaviour, expressed in ticks since walking/hit began
   task automatic model_edge(input bit l, input bit r, input bit u, input bit d,
                             input bit hr, input bit ft);
      int dx, dy;
      dx = STEP * (int'(r) - int'(l));
      dy = STEP * (int'(d) - int'(u));
      if (m_hit != 0) begin
         if (ft) begin
            m_hit_ticks++;
            if (m_hit_ticks == HITF) begin
               m_hit = 0; m_pose = 0; m_show = 1; m_walking = 1'b0;
            end else begin
               m_show = ((m_hit_ticks / BLINK) % 2 == 0) ? 1 : 0;
            end
         end
      end else if (hr) begin
         m_hit = 1; m_hit_ticks = 0; m_pose = 2; m_show = 1;
      end else if (ft) begin
         if (dx == 0 && dy == 0) begin
            m_walking = 1'b0; m_pose = 0;
         end else begin
            if (!m_walking) begin
               m_walking = 1'b1; m_walk_idx = 0;
            end else begin
               m_walk_idx++;
            end
            m_pose = ((m_walk_idx / ANIM) % 2 == 0) ? 1 : 0;
            m_x = clampi(m_x + dx, XMIN, XMAX);
            m_y = clampi(m_y + dy, YMIN, YMAX);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".centerx"},    32'(centerx),    32'(m_x));
      chk({tag, ".centery"},    32'(centery),    32'(m_y));
      chk({tag, ".run_child"},  32'(run_child),  32'(m_pose));
      chk({tag, ".hit"},        32'(hit),        32'(m_hit));
      chk({tag, ".show_child"}, 32'(show_child), 32'(m_show));
   endtask

   // Drive one cycle, let the edge happen, update the model and compare
   task automatic step(input string tag, input bit l, input bit r, input bit u,
                       input bit d, input bit hr, input bit ft);
      @(negedge Clk);
      move_left = l; move_right = r; move_up = u; move_down = d;
      hit_req = hr; frame_tick = ft;
      @(posedge Clk);
      model_edge(l, r, u, d, hr, ft);
      #1;
      chk_all(tag);
      hit_req = 1'b0;
      frame_tick = 1'b0;
   endtask

   // A frame: one tick cycle followed by one idle cycle
   task automatic frame(input string tag, input bit l, input bit r, input bit u,
                        input bit d);
      step(tag, l, r, u, d, 1'b0, 1'b1);
      step(tag, l, r, u, d, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      int y_before;
      bit kl, kr, ku, kd, hr, ft;

      // Reset values
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      chk("reset.centerx", 32'(centerx), 32'd320);
      chk("reset.centery", 32'(centery), 32'd240);
      chk("reset.run_child", 32'(run_child), 32'd0);
      chk("reset.hit", 32'(hit), 32'd0);
      chk("reset.show_child", 32'(show_child), 32'd1);
      @(negedge Clk);
      Reset_n = 1'b1;
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Walk right for 20 ticks
      for (int i = 1; i <= 20; i++) begin
         frame("walk_right", 1'b0, 1'b1, 1'b0, 1'b0);
         if (i == 1) begin
            chk("walk.t1.x", 32'(centerx), 32'd322);
            chk("walk.t1.pose", 32'(run_child), 32'd1);
         end
         if (i == 9)  chk("walk.t9.pose", 32'(run_child), 32'd0);
         if (i == 17) chk("walk.t17.pose", 32'(run_child), 32'd1);
      end
      chk("walk.t20.x", 32'(centerx), 32'd360);
      frame("release", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("release.pose", 32'(run_child), 32'd0);
      chk("release.x", 32'(centerx), 32'd360);

      // Opposing keys
      do_reset();
      frame("opposing", 1'b1, 1'b1, 1'b1, 1'b0);
      chk("opp.x", 32'(centerx), 32'd320);
      chk("opp.y", 32'(centery), 32'd238);
      chk("opp.pose", 32'(run_child), 32'd1);

      // Clamp at the left and bottom edges
      for (int i = 0; i < 150; i++) frame("left", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("clamp.xmin", 32'(centerx), 32'd29);
      for (int i = 0; i < 110; i++) frame("down", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("clamp.ymax", 32'(centery), 32'd449);

      // Hit while running; moves and a second hit_req are ignored
      step("hit.entry", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("hit.entry.hit", 32'(hit), 32'd1);
      chk("hit.entry.pose", 32'(run_child), 32'd2);
      for (int i = 1; i <= HITF; i++) begin
         step("hit.tick", 1'b0, 1'b1, 1'b1, 1'b0, (i == 30), 1'b1);
         step("hit.gap", 1'b0, 1'b1, 1'b1, 1'b0, (i == 20), 1'b0);
         if (i == 4)  chk("hit.blink4", 32'(show_child), 32'd0);
         if (i == 8)  chk("hit.blink8", 32'(show_child), 32'd1);
         if (i == 59) chk("hit.still59", 32'(hit), 32'd1);
      end
      chk("hit.exit.hit", 32'(hit), 32'd0);
      chk("hit.exit.pose", 32'(run_child), 32'd0);
      chk("hit.exit.show", 32'(show_child), 32'd1);
      chk("hit.exit.x", 32'(centerx), 32'd29);

      // Collision on the frame edge with move_up held
      frame("up", 1'b0, 1'b0, 1'b1, 1'b0);
      frame("up", 1'b0, 1'b0, 1'b1, 1'b0);
      y_before = m_y;
      step("coll", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("coll.hit", 32'(hit), 32'd1);
      chk("coll.y", 32'(centery), 32'(y_before));
      frame("coll.run", 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-HIT, between clock edges
      #2;
      Reset_n = 1'b0;
      #1;
      chk("areset.centerx", 32'(centerx), 32'd320);
      chk("areset.centery", 32'(centery), 32'd240);
      chk("areset.run_child", 32'(run_child), 32'd0);
      chk("areset.hit", 32'(hit), 32'd0);
      chk("areset.show_child", 32'(show_child), 32'd1);
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;

      // Random stimulus against the model
      {kl, kr, ku, kd} = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) {kl, kr, ku, kd} = 4'($urandom_range(0, 15));
         ft = ($urandom_range(0, 3) == 0);
         hr = ($urandom_range(0, 199) == 0);
         step("rand", kl, kr, ku, kd, hr, ft);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
